// File: rtl/mgt_01_divide_unit.sv
// mgt_01_divide_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module mgt_01_divide_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [1:0]      operation_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            fu_state_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] DIV_ = 2'd0;
  localparam logic [1:0] REM_ = 2'd2;
  localparam logic FREE = 1'b0;
  localparam logic BUSY = 1'b1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FINALIZE = 2'd2;
  logic [1:0]      state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic            special_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] fin_val;
  // operand conditioning, one restoring step and the final sign fix-up
  always_comb begin
    signed_op = ~operation_i[0];
    a_neg     = signed_op & dividend_i[XLEN-1];
    b_neg     = signed_op & divisor_i[XLEN-1];
    a_mag     = a_neg ? -dividend_i : dividend_i;
    b_mag     = b_neg ? -divisor_i : divisor_i;
    div_zero  = divisor_i == '0;
    ovf       = signed_op && dividend_i == {1'b1, {(XLEN-1){1'b0}}} && (&divisor_i);
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    q_fin     = (op_q == DIV_ && !special_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    r_fin     = (op_q == REM_ && !special_q && sign_a_q) ? -rem_q : rem_q;
    fin_val   = op_q[1] ? r_fin : q_fin;
  end
  assign fu_state_o = (state_q == IDLE) ? FREE : BUSY;
  // control FSM and datapath registers; flush wins over everything outside IDLE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_o  <= '0;
      valid_o   <= 1'b0;
    end else if (clk_en_i) begin
      valid_o <= 1'b0;
      if (flush_i && state_q != IDLE) begin
        state_q <= IDLE;
      end else if (state_q == IDLE) begin
        if (valid_i) begin
          op_q      <= operation_i;
          sign_a_q  <= a_neg;
          sign_b_q  <= b_neg;
          dvs_q     <= b_mag;
          special_q <= div_zero | ovf;
          cnt_q     <= '0;
          if (div_zero) begin
            quo_q   <= '1;
            rem_q   <= dividend_i;
            state_q <= FINALIZE;
          end else if (ovf) begin
            quo_q   <= dividend_i;
            rem_q   <= '0;
            state_q <= FINALIZE;
          end else begin
            quo_q   <= a_mag;
            rem_q   <= '0;
            state_q <= DIVIDE;
          end
        end
      end else if (state_q == DIVIDE) begin
        rem_q   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_q   <= {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_q   <= (cnt_q == CW'(XLEN-1)) ? cnt_q : cnt_q + 1'b1;
        state_q <= (cnt_q == CW'(XLEN-1)) ? FINALIZE : DIVIDE;
      end else begin
        result_o <= fin_val;
        valid_o  <= 1'b1;
        state_q  <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mgt_01_divide_unit.sv
// tb_mgt_01_divide_unit: directed and random checks of the divide unit against an arithmetic model
module tb_mgt_01_divide_unit;
  localparam logic [1:0] DIV_ = 2'd0;
  localparam logic [1:0] DIVU_ = 2'd1;
  localparam logic [1:0] REM_ = 2'd2;
  localparam logic [1:0] REMU_ = 2'd3;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        clk_en_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [1:0]  operation_i = '0;
  logic [31:0] result_o;
  logic        valid_o;
  logic        fu_state_o;
  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  mgt_01_divide_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .valid_i(valid_i),
    .flush_i(flush_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .operation_i(operation_i), .result_o(result_o), .valid_o(valid_o),
    .fu_state_o(fu_state_o)
  );

  function automatic logic [31:0] model_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      DIV_:    return sa / sb;
      DIVU_:   return a / b;
      REM_:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_latency(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    operation_i = op;
    dividend_i  = a;
    divisor_i   = b;
    valid_i     = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int busy);
    n = 0;
    busy = int'(fu_state_o);
    while (!valid_o && n < 200) begin
      tick();
      n++;
      if (fu_state_o) busy++;
    end
  endtask

  logic [1:0]  d_op [10] = '{DIVU_, REMU_, DIV_, REM_, REM_, DIV_, DIVU_, REM_, DIV_, REM_};
  logic [31:0] d_a  [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                             32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b  [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp[10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
  int          d_lat[10] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

  initial begin
    int n;
    int busy;
    int hits;
    logic [31:0] last_res;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    tick();
    tick();
    check("reset_result", result_o, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_fu_state", {31'd0, fu_state_o}, 32'd0);
    rst_n_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      start(d_op[i], d_a[i], d_b[i]);
      wait_valid(n, busy);
      check($sformatf("dir%0d_result", i), result_o, d_exp[i]);
      check($sformatf("dir%0d_latency", i), n, d_lat[i]);
      check($sformatf("dir%0d_busy", i), busy, d_lat[i]);
      tick();
      check($sformatf("dir%0d_pulse", i), {31'd0, valid_o}, 32'd0);
    end
    start(DIVU_, 32'd1000003, 32'd97);
    repeat (5) tick();
    clk_en_i    = 1'b0;
    operation_i = REMU_;
    dividend_i  = 32'd55;
    divisor_i   = 32'd4;
    valid_i     = 1'b1;
    repeat (10) tick();
    clk_en_i = 1'b1;
    tick();
    valid_i = 1'b0;
    wait_valid(n, busy);
    last_res = model_result(DIVU_, 32'd1000003, 32'd97);
    check("stall_result", result_o, last_res);
    check("stall_latency", 16 + n, 43);
    hits = 0;
    repeat (40) begin
      tick();
      if (valid_o) hits++;
    end
    check("stall_extra_ignored", hits, 0);
    check("stall_free", {31'd0, fu_state_o}, 32'd0);
    start(DIVU_, 32'd500, 32'd3);
    repeat (14) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_free", {31'd0, fu_state_o}, 32'd0);
    check("flush_valid", {31'd0, valid_o}, 32'd0);
    check("flush_result_kept", result_o, last_res);
    hits = 0;
    repeat (40) begin
      tick();
      if (valid_o) hits++;
    end
    check("flush_no_valid", hits, 0);
    start(DIVU_, 32'd12345, 32'd7);
    repeat (10) tick();
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_result", result_o, 32'd0);
    check("async_rst_valid", {31'd0, valid_o}, 32'd0);
    check("async_rst_free", {31'd0, fu_state_o}, 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    start(DIVU_, 32'hFFFF_FFFF, 32'd1);
    wait_valid(n, busy);
    check("post_rst_result", result_o, 32'hFFFF_FFFF);
    check("post_rst_latency", n, 33);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      start(op, a, b);
      wait_valid(n, busy);
      check($sformatf("rnd%0d_op%0d_%08h_%08h", i, op, a, b), result_o, model_result(op, a, b));
      check($sformatf("rnd%0d_latency", i), n, model_latency(op, a, b));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
